// File: rtl/riscv_pkg.sv
// riscv_pkg: load/store funct3 encodings and LSU state type shared by the LSU files
package riscv_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request, response and data-memory signals of the load/store unit
interface lsu_ctrl_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [4:0]        resp_rd;
    logic              resp_fault;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic [31:0]       d_rdata;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready, d_rdata,
        output req_ready, resp_valid, resp_data, resp_rd, resp_fault, d_addr, d_wdata, d_wstrb
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready, d_rdata,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_fault, d_addr, d_wdata, d_wstrb
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: strobe/lane replication for stores, byte/half extraction and extension for loads
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        fault
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        illegal;
    logic        misal;
    always_comb begin
        b         = rdata[{off, 3'b000} +: 8];
        h         = off[1] ? rdata[31:16] : rdata[15:0];
        // unsigned variants exist only for loads
        illegal   = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2]);
        misal     = (funct3[1:0] == 2'b01 && off[0]) || (funct3 == F3_W && off != 2'b00);
        fault     = illegal || misal;
        strb      = funct3[1:0] == 2'b00 ? 4'b0001 << off :
                    funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata_rep = funct3 == F3_B ? {4{wdata[7:0]}} :
                    funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
        rdata_ext = funct3 == F3_B  ? {{24{b[7]}}, b} :
                    funct3 == F3_H  ? {{16{h[15]}}, h} :
                    funct3 == F3_BU ? {24'b0, b} :
                    funct3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit in front of the data memory
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic        clk,
    input logic        rst,
    lsu_ctrl_if.slave  bus
);
    lsu_state_e        state;
    lsu_state_e        state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       resp_data_q;
    logic [4:0]        resp_rd_q;
    logic              resp_fault_q;
    logic [3:0]        strb;
    logic [31:0]       wrep;
    logic [31:0]       ext;
    logic              fault;
    lsu_align u_align (
        .funct3    (f3_q),
        .we        (we_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus.d_rdata),
        .strb      (strb),
        .wdata_rep (wrep),
        .rdata_ext (ext),
        .fault     (fault)
    );
    always_comb begin
        state_nx       = state == IDLE   ? (bus.req_valid ? ACCESS : IDLE) :
                         state == ACCESS ? RESP : (bus.resp_ready ? IDLE : RESP);
        bus.req_ready  = state == IDLE;
        bus.resp_valid = state == RESP;
        // strobe is combinational so an async reset in ACCESS kills the write before the edge
        bus.d_wstrb    = (state == ACCESS && we_q && !fault) ? strb : 4'b0000;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'b0;
            rd_q         <= 5'b0;
            resp_data_q  <= 32'b0;
            resp_rd_q    <= 5'b0;
            resp_fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rd_q    <= bus.req_rd;
            end
            if (state == ACCESS) begin
                resp_data_q  <= (we_q || fault) ? 32'b0 : ext;
                resp_rd_q    <= rd_q;
                resp_fault_q <= fault;
            end
        end
    end
    assign bus.d_addr     = addr_q;
    assign bus.d_wdata    = wrep;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_fault = resp_fault_q;
endmodule
